// File: rtl/mc_ctrl_pkg.sv
// Shared types and codes for the multicycle RISC-V controller: state enum,
// opcode/funct3/ALU/mux encodings and the per-state control word decode.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_WB_MEM = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC_R = 4'd7,
    S_WB_R   = 4'd8,
    S_BRANCH = 4'd9,
    S_TRAP   = 4'd10
  } mc_state_e;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_SW  = 3'b010;
  localparam logic [2:0] OP_R   = 3'b011;
  localparam logic [2:0] OP_BEQ = 3'b110;

  localparam logic [2:0] F3_SUB = 3'b000;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SRL = 3'b101;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0101;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // Moore part of the datapath control; pcwrite/irwrite depend on inputs
  // and are produced outside this word.
  typedef struct packed {
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       regiwrite;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       pcsource;
    logic [3:0] alucontrol;
  } mc_ctrl_t;

  function automatic mc_ctrl_t state_ctrl(input mc_state_e s, input logic [3:0] alu_r);
    mc_ctrl_t c;
    c            = '0;
    c.alucontrol = ALU_ADD;
    case (s)
      S_FETCH: begin
        c.memread = 1'b1;
        c.alusrcb = SRCB_FOUR;
      end
      S_DECODE: c.alusrcb = SRCB_IMM;
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        c.memread = 1'b1;
        c.iord    = 1'b1;
      end
      S_WB_MEM: begin
        c.regiwrite = 1'b1;
        c.memtoreg  = 1'b1;
      end
      S_MEMWR: begin
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
      end
      S_EXEC_R: begin
        c.alusrca    = 1'b1;
        c.alusrcb    = SRCB_RS2;
        c.alucontrol = alu_r;
      end
      S_WB_R: begin
        c.regiwrite  = 1'b1;
        c.alucontrol = alu_r;
      end
      S_BRANCH: begin
        c.alusrca    = 1'b1;
        c.alusrcb    = SRCB_RS2;
        c.alucontrol = ALU_SUB;
        c.pcsource   = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_ctrl_alu_decode.sv
// R-type funct3 to ALU operation decode with a legality flag.
module mc_alu_decode
  import mc_ctrl_pkg::*;
(
  input  logic [2:0] funct3_i,
  output logic [3:0] alucontrol_o,
  output logic       legal_o
);

  always_comb begin
    alucontrol_o = ALU_ADD;
    legal_o      = 1'b1;
    case (funct3_i)
      F3_SUB:  alucontrol_o = ALU_SUB;
      F3_XOR:  alucontrol_o = ALU_XOR;
      F3_SRL:  alucontrol_o = ALU_SRL;
      default: legal_o      = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore controller for the shared-memory multicycle RISC-V datapath.
// Optional performance counters are enabled with `define MC_PERF_CNT_EN.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15
`ifdef MC_PERF_CNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] tipo,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       memread,
  output logic       memwrite,
  output logic       regiwrite,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       pcsource,
  output logic [3:0] alucontrol,
  output logic       illegal,
  output mc_state_e  state_o
`ifdef MC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  localparam int WAIT_W = $clog2(WAIT_MAX + 1);

  mc_state_e         state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              illegal_q;
  mc_ctrl_t          ctrl_q;
  logic [3:0]        dec_alu, alu_sel;
  logic              dec_legal;
  logic              fetch_done;

  mc_alu_decode u_alu_decode (
    .funct3_i     (funct3),
    .alucontrol_o (dec_alu),
    .legal_o      (dec_legal)
  );

  // The wait counter only survives while a memory state holds; any other
  // transition (including entry) leaves it at zero.
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH, S_MEMRD, S_MEMWR: begin
        if (mem_ready) begin
          case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_MEMRD: state_d = S_WB_MEM;
            default: state_d = S_FETCH;
          endcase
        end else if (wait_q == WAIT_W'(WAIT_MAX - 1)) begin
          state_d = S_TRAP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: begin
        case (tipo)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = dec_legal ? S_EXEC_R : S_TRAP;
          OP_BEQ:       state_d = S_BRANCH;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: state_d = (tipo == OP_SW) ? S_MEMWR : S_MEMRD;
      S_EXEC_R: state_d = S_WB_R;
      S_WB_MEM, S_WB_R, S_BRANCH: state_d = S_FETCH;
      default: state_d = S_TRAP;
    endcase
  end

  // WB_R keeps the operation latched on entry to EXEC_R.
  always_comb begin
    alu_sel = (state_d == S_EXEC_R) ? dec_alu : ctrl_q.alucontrol;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_RESET;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      ctrl_q    <= state_ctrl(S_RESET, ALU_ADD);
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ctrl_q  <= state_ctrl(state_d, alu_sel);
      if (state_d == S_TRAP) begin
        illegal_q <= 1'b1;
      end
    end
  end

  assign fetch_done = (state_q == S_FETCH) && mem_ready && !illegal_q;

  assign irwrite    = fetch_done;
  assign pcwrite    = fetch_done || ((state_q == S_BRANCH) && zero && !illegal_q);
  assign iord       = ctrl_q.iord;
  assign memread    = ctrl_q.memread;
  assign memwrite   = ctrl_q.memwrite;
  assign regiwrite  = ctrl_q.regiwrite;
  assign memtoreg   = ctrl_q.memtoreg;
  assign alusrca    = ctrl_q.alusrca;
  assign alusrcb    = ctrl_q.alusrcb;
  assign pcsource   = ctrl_q.pcsource;
  assign alucontrol = ctrl_q.alucontrol;
  assign illegal    = illegal_q;
  assign state_o    = state_q;

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q, instret_q;
  logic             retire;

  always_comb begin
    retire = (state_d == S_FETCH) &&
             (state_q inside {S_WB_MEM, S_MEMWR, S_WB_R, S_BRANCH});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state_q != S_RESET && state_q != S_TRAP) begin
        cycle_q <= cycle_q + 1'b1;
      end
      if (retire) begin
        instret_q <= instret_q + 1'b1;
      end
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`endif

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore FSM controller that sequences a shared-memory multicycle RISC-V datapath (PC, IR, register file, ALU, ALUOut, MDR, single instruction/data memory).
- Supports the team's instruction subset: lw, sw, sub, xor, srl, beq.
- Replaces the single-cycle decoder when instruction and data share one memory port with a ready handshake.
- Drives every datapath enable and mux select per state; detects illegal encodings and memory timeouts.

Parameters:
- WAIT_MAX, 15, maximum cycles a memory state waits for mem_ready before trapping.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- tipo  in  3  opcode[6:4] from IR: 000 lw, 010 sw, 011 R-type, 110 beq.
- funct3  in  3  IR funct3; R-type: 000 sub, 100 xor, 101 srl.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completed current access this cycle.
- pcwrite  out  1  PC load (unconditional, or beq taken).
- iord  out  1  memory address source: 0 = PC, 1 = ALUOut.
- irwrite  out  1  IR load.
- memread  out  1  memory read request.
- memwrite  out  1  memory write request.
- regiwrite  out  1  register file write.
- memtoreg  out  1  writeback source: 0 = ALUOut, 1 = MDR.
- alusrca  out  1  ALU A: 0 = PC, 1 = rs1.
- alusrcb  out  2  ALU B: 00 rs2, 01 constant 4, 10 immediate.
- pcsource  out  1  PC input: 0 = ALU result, 1 = ALUOut.
- alucontrol  out  4  0010 add, 0110 sub, 0011 xor, 0101 srl.
- illegal  out  1  sticky trap flag.

Behaviour:
- State register updates on posedge clk; all outputs are decoded combinationally from the state, except pcwrite in BRANCH.
- Reset (async): state = RESET; illegal = 0; wait counter = 0. In RESET all outputs are 0, and alucontrol = 0010.
- RESET -> FETCH unconditionally.
- FETCH: memread = 1, iord = 0, alusrca = 0, alusrcb = 01, alucontrol = add. While mem_ready = 0 the state holds. When mem_ready = 1: irwrite = 1, pcwrite = 1, pcsource = 0, and the FSM moves to DECODE.
- DECODE: alusrca = 0, alusrcb = 10, alu add (branch target into ALUOut). Next state:
  - lw or sw -> MEMADR.
  - 011 with a legal funct3 -> EXEC_R.
  - 110 -> BRANCH.
  - Anything else -> TRAP.
- MEMADR: alusrca = 1, alusrcb = 10, add. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: memread = 1, iord = 1. Holds until mem_ready, then -> WB_MEM.
- WB_MEM: regiwrite = 1, memtoreg = 1 -> FETCH.
- MEMWR: memwrite = 1, iord = 1. Holds until mem_ready, then -> FETCH.
- EXEC_R: alusrca = 1, alusrcb = 00, alucontrol from funct3 -> WB_R.
- WB_R: regiwrite = 1, memtoreg = 0, alucontrol held -> FETCH.
- BRANCH: alusrca = 1, alusrcb = 00, sub, pcsource = 1, pcwrite = zero (combinational) -> FETCH.
- TRAP: all enables 0, illegal = 1. Remains in TRAP until reset.
- Minimum latency (zero-wait memory): lw 5, sw 4, R-type 4, beq 3 cycles.
- Wait counter:
  - Clears on entry to FETCH, MEMRD or MEMWR.
  - Increments each cycle the FSM waits in one of those states.
  - If it reaches WAIT_MAX with mem_ready still 0 -> TRAP. mem_ready in that same cycle wins.
- Write enables (regiwrite, memwrite, pcwrite, irwrite) are never asserted simultaneously with illegal = 1.
- Reset mid-instruction: the FSM returns to RESET immediately; no write enable is asserted afterwards.

Optional Feature:
- Macro MC_PERF_CNT_EN.
- Defined: adds outputs cycle_cnt[CNT_W-1:0] and instret_cnt[CNT_W-1:0], both reset to 0 and wrapping modulo 2^CNT_W.
  - cycle_cnt increments every cycle not in RESET or TRAP.
  - instret_cnt increments on each transition into FETCH from WB_MEM, MEMWR, WB_R or BRANCH.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package mc_ctrl_pkg holds:
  - the state enum;
  - tipo codes (OP_LW 000, OP_SW 010, OP_R 011, OP_BEQ 110);
  - funct3 codes;
  - alucontrol codes;
  - alusrcb select codes.
- One sub-module, mc_alu_decode: combinational decode of funct3 to alucontrol plus a legal flag, used by DECODE and EXEC_R.

Test Plan:
- lw, tipo = 000, mem_ready always 1 -> states FETCH, DECODE, MEMADR, MEMRD, WB_MEM; regiwrite = 1 and memtoreg = 1 in cycle 5; irwrite = 1 in cycle 1.
- sw with mem_ready delayed 3 cycles in MEMWR -> memwrite held for 4 cycles with iord = 1; no regiwrite; back to FETCH.
- R-type, funct3 = 100 then 101 -> alucontrol 0011 then 0101 in EXEC_R and WB_R; regiwrite = 1 in WB_R only.
- beq with zero = 1 -> pcwrite = 1, pcsource = 1 in BRANCH. Repeat with zero = 0 -> pcwrite = 0.
- tipo = 011, funct3 = 001 -> TRAP, illegal = 1 and sticky. Separately, mem_ready held low for 15 cycles in FETCH -> TRAP.
- Assert reset during MEMWR -> memwrite = 0 immediately; all outputs 0 and illegal = 0; FETCH resumes one cycle after reset deasserts.
